// File: rtl/alu32_pkg.sv
// Shared types for the 32-bit ALU: opcode encoding, flag bundle and datapath width.
package alu32_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOR   = 4'd5,
    OP_SLT   = 4'd6,
    OP_SLTU  = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_SRA   = 4'd10,
    OP_PASSB = 4'd11,
    OP_PASSA = 4'd12,
    OP_NAND  = 4'd13,
    OP_XNOR  = 4'd14,
    OP_MUL   = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu32_addsub.sv
// Single shared 33-bit adder; sub=1 computes a + ~b + 1 so carry=1 means no borrow.
module alu32_addsub
  import alu32_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   total;

  assign b_eff    = b ^ {WIDTH{sub}};
  assign total    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum      = total[WIDTH-1:0];
  assign carry    = total[WIDTH];
  // Operand signs equal (after inversion for subtract) but result sign differs.
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_32.sv
// 32-bit combinational ALU with a clocked N/Z/C/V flag register.
// Define ALU32_MUL_EN to make op 15 a low-word multiply; otherwise op 15 returns zero.
module alu_32
  import alu32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             flag_we,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [3:0]       flags_q
);

  alu_op_e          op_e;
  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] res;
  logic             c_flag;
  logic             v_flag;
  alu_flags_t       flags_d;
  alu_flags_t       flags_r;

  assign op_e  = alu_op_e'(op);
  assign shamt = b[4:0];
  // Compares reuse the subtractor, so the adder is the only carry chain.
  assign sub   = (op_e == OP_SUB) || (op_e == OP_SLT) || (op_e == OP_SLTU);

  alu32_addsub u_addsub (
    .a        (a),
    .b        (b),
    .sub      (sub),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    unique case (op_e)
      OP_ADD, OP_SUB: begin
        res    = sum;
        c_flag = carry;
        v_flag = overflow;
      end
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOR:   res = ~(a | b);
      OP_SLT:   res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ overflow};
      OP_SLTU:  res = {{(WIDTH-1){1'b0}}, ~carry};
      OP_SLL:   res = a << shamt;
      OP_SRL:   res = a >> shamt;
      OP_SRA:   res = $unsigned($signed(a) >>> shamt);
      OP_PASSB: res = b;
      OP_PASSA: res = a;
      OP_NAND:  res = ~(a & b);
      OP_XNOR:  res = ~(a ^ b);
      OP_MUL: begin
`ifdef ALU32_MUL_EN
        res = a * b;
`else
        res = '0;
`endif
      end
      default:  res = '0;
    endcase
  end

  assign y    = res;
  assign zero = (res == '0);

  always_comb begin
    flags_d = flags_r;
    if (flag_we) begin
      flags_d.n = res[WIDTH-1];
      flags_d.z = zero;
      flags_d.c = c_flag;
      flags_d.v = v_flag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_r <= '0;
    else        flags_r <= flags_d;
  end

  assign flags_q = flags_r;

endmodule

// File: tb/tb_alu_32.sv
// Directed, table-driven check of alu_32 results, zero and captured flags.
module tb_alu_32;
  import alu32_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        flag_we;
  logic [31:0] y;
  logic        zero;
  logic [3:0]  flags_q;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[$];

  alu_32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .op      (op),
    .flag_we (flag_we),
    .y       (y),
    .zero    (zero),
    .flags_q (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    flag_we = 1'b1;
    op      = OP_ADD;
    a       = 32'h7FFF_FFFF;
    b       = 32'h0000_0001;

    //          op        a             b             y             NZCV
    vecs.push_back('{OP_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001});
    vecs.push_back('{OP_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110});
    vecs.push_back('{OP_SUB,   32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0110});
    vecs.push_back('{OP_SUB,   32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000});
    vecs.push_back('{OP_SUB,   32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011});
    vecs.push_back('{OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000});
    vecs.push_back('{OP_OR,    32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 4'b0000});
    vecs.push_back('{OP_XOR,   32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 4'b1000});
    vecs.push_back('{OP_NOR,   32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 4'b0100});
    vecs.push_back('{OP_NOR,   32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1000});
    vecs.push_back('{OP_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000});
    vecs.push_back('{OP_SLT,   32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100});
    vecs.push_back('{OP_SLT,   32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 4'b0000});
    vecs.push_back('{OP_SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0100});
    vecs.push_back('{OP_SLTU,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000});
    vecs.push_back('{OP_SLL,   32'h0000_0001, 32'hFFFF_FFE1, 32'h0000_0002, 4'b0000});
    vecs.push_back('{OP_SLL,   32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b1000});
    vecs.push_back('{OP_SRL,   32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 4'b0000});
    vecs.push_back('{OP_SRA,   32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4'b1000});
    vecs.push_back('{OP_SRA,   32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0000, 4'b0100});
    vecs.push_back('{OP_PASSB, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1000});
    vecs.push_back('{OP_PASSA, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 4'b0000});
    vecs.push_back('{OP_NAND,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100});
    vecs.push_back('{OP_NAND,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_FFFF, 4'b1000});
    vecs.push_back('{OP_XNOR,  32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 4'b1000});
`ifdef ALU32_MUL_EN
    vecs.push_back('{OP_MUL,   32'h0000_0003, 32'h0000_0007, 32'h0000_0015, 4'b0000});
    vecs.push_back('{OP_MUL,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 4'b1000});
`else
    vecs.push_back('{OP_MUL,   32'h0000_0003, 32'h0000_0007, 32'h0000_0000, 4'b0100});
    vecs.push_back('{OP_MUL,   32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 4'b0100});
`endif

    // Reset wins over flag_we; y stays live during reset.
    @(posedge clk); #1;
    chk("reset_flags", {28'd0, flags_q}, 32'd0);
    chk("reset_y_live", y, 32'h8000_0000);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; flag_we = 1'b1;
      #1;
      chk($sformatf("y[%0d]", i), y, vecs[i].y);
      chk($sformatf("zero[%0d]", i), {31'd0, zero}, {31'd0, (vecs[i].y == 32'd0)});
      @(posedge clk); #1;
      chk($sformatf("flags[%0d]", i), {28'd0, flags_q}, {28'd0, vecs[i].f});
    end

    // Capture 1001, then hold with flag_we low across an op change.
    @(negedge clk);
    op = OP_ADD; a = 32'h7FFF_FFFF; b = 32'h0000_0001; flag_we = 1'b1;
    @(posedge clk); #1;
    chk("capture_1001", {28'd0, flags_q}, 32'h9);
    @(negedge clk);
    op = OP_SUB; a = 32'h5; b = 32'h5; flag_we = 1'b0;
    @(posedge clk); #1;
    chk("hold_flags", {28'd0, flags_q}, 32'h9);
    @(posedge clk); #1;
    chk("hold_flags_2", {28'd0, flags_q}, 32'h9);
    chk("hold_zero", {31'd0, zero}, 32'd1);

    // Reset asserted with flag_we in the same cycle clears the register.
    @(negedge clk);
    op = OP_ADD; a = 32'h7FFF_FFFF; b = 32'h0000_0001; flag_we = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_prio", {28'd0, flags_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_capture", {28'd0, flags_q}, 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
